// File: rtl/prime_bench_pkg.sv
// Shared types for the primogen benchmark controller: FSM states and fail codes.
package prime_bench_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        FAIL
    } state_t;

    typedef logic [1:0] fail_code_t;

    localparam fail_code_t FC_NONE      = 2'd0;
    localparam fail_code_t FC_EARLY_ERR = 2'd1;
    localparam fail_code_t FC_ORDER     = 2'd2;
    localparam fail_code_t FC_TIMEOUT   = 2'd3;

endpackage

// File: rtl/prime_bench_ctrl_if.sv
// Request/result handshake between the benchmark controller and primogen.
interface prime_bench_ctrl_if #(
    parameter int W = 16
);
    logic         pg_go;
    logic         pg_ready;
    logic         pg_error;
    logic [W-1:0] pg_res;

    modport master (output pg_go, input pg_ready, input pg_error, input pg_res);
    modport slave  (input pg_go, output pg_ready, output pg_error, output pg_res);
endinterface

// File: rtl/prime_bench_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + ONE;
        end
    end
endmodule

// File: rtl/prime_bench_ctrl.sv
// Benchmark controller for primogen: issues requests, checks ordering, counts primes and cycles,
// and reports the outcome on sticky done/fail flags and status LEDs.
module prime_bench_ctrl
    import prime_bench_pkg::*;
#(
    parameter int          W         = 16,
    parameter int unsigned LIMIT     = 1000,
    parameter int unsigned MODE      = 0,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int          NLED      = 5,
    parameter int          BLINK_LOG = 22
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    prime_bench_ctrl_if.master        pg,
    output logic [W-1:0]              last_prime,
    output logic [31:0]               prime_count,
    output logic [31:0]               cycles,
    output logic                      done,
    output logic                      fail,
    output fail_code_t                fail_code,
    output logic [NLED-1:0]           led
);
    localparam logic [BLINK_LOG:0] BLINK_ONE = {{BLINK_LOG{1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    fail_code_t         fc_nxt;
    logic               holdoff;
    logic               ready_eff;
    logic               order_ok;
    logic               accept;
    logic               timeout_hit;
    logic               start_run;
    logic [31:0]        wait_cnt;
    logic [BLINK_LOG:0] blink_cnt;

    // primogen registers pg_go, so its ready in the following cycle still reflects the old result
    assign ready_eff   = pg.pg_ready && !holdoff;
    assign order_ok    = (prime_count == 32'd0) ? (pg.pg_res >= W'(2)) : (pg.pg_res > last_prime);
    assign timeout_hit = (wait_cnt == (TIMEOUT - 32'd1));
    assign start_run   = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt = state;
        fc_nxt    = FC_NONE;
        accept    = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (ready_eff) begin
                    if (pg.pg_error) begin
                        if (MODE == 1) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = FAIL;
                            fc_nxt    = FC_EARLY_ERR;
                        end
                    end else if (!order_ok) begin
                        state_nxt = FAIL;
                        fc_nxt    = FC_ORDER;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ((MODE == 0) && ((prime_count + 32'd1) == LIMIT)) ? DONE : ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_nxt = FAIL;
                    fc_nxt    = FC_TIMEOUT;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        pg.pg_go = (state == ISSUE);
        done     = (state == DONE);
        fail     = (state == FAIL);
        led      = '0;
        led[NLED-2:0] = last_prime[W-1 -: NLED-1];
        led[NLED-1]   = done || (fail && !blink_cnt[BLINK_LOG]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff    <= 1'b0;
            fail_code  <= FC_NONE;
            last_prime <= '0;
            blink_cnt  <= '0;
        end else begin
            holdoff <= (state == ISSUE);
            // fc_nxt is FC_NONE on every WAIT exit except into FAIL, so this latches the cause once
            if (state == WAIT) fail_code <= fc_nxt;
            if (accept) last_prime <= pg.pg_res;
            if (state == FAIL) blink_cnt <= blink_cnt + BLINK_ONE;
        end
    end

    sat_counter #(.WIDTH(32)) u_prime_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_run),
        .enable (accept),
        .count  (prime_count)
    );

    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_run),
        .enable ((state == ISSUE) || (state == WAIT)),
        .count  (cycles)
    );

    // the holdoff cycle counts toward the timeout even though ready is ignored there
    sat_counter #(.WIDTH(32)) u_wait_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ISSUE),
        .enable ((state == WAIT) && !ready_eff),
        .count  (wait_cnt)
    );
endmodule

// File: tb/tb_prime_bench_ctrl.sv
// Bench for prime_bench_ctrl: behavioural primogen models feed two controller instances and a
// scoreboard of expected accepts is compared against each prime_count step.
module tb_prime_bench_ctrl;
    import prime_bench_pkg::*;

    typedef struct { int unsigned cnt; logic [15:0] last; } exp_t;
    typedef struct { logic err; logic [15:0] res; } rep_t;

    logic clk = 1'b0;
    logic rst_n, start_a, start_b;

    logic [15:0] last_prime_a;
    logic [31:0] prime_count_a, cycles_a;
    logic        done_a, fail_a;
    fail_code_t  fail_code_a;
    logic [4:0]  led_a;

    logic [7:0]  last_prime_b;
    logic [31:0] prime_count_b, cycles_b;
    logic        done_b, fail_b;
    fail_code_t  fail_code_b;
    logic [4:0]  led_b;

    prime_bench_ctrl_if #(.W(16)) pgif_a ();
    prime_bench_ctrl_if #(.W(8))  pgif_b ();

    prime_bench_ctrl #(.W(16), .LIMIT(5), .MODE(0), .TIMEOUT(10), .NLED(5), .BLINK_LOG(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pg(pgif_a),
        .last_prime(last_prime_a), .prime_count(prime_count_a), .cycles(cycles_a),
        .done(done_a), .fail(fail_a), .fail_code(fail_code_a), .led(led_a)
    );

    prime_bench_ctrl #(.W(8), .LIMIT(1000), .MODE(1), .TIMEOUT(10), .NLED(5), .BLINK_LOG(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pg(pgif_b),
        .last_prime(last_prime_b), .prime_count(prime_count_b), .cycles(cycles_b),
        .done(done_b), .fail(fail_b), .fail_code(fail_code_b), .led(led_b)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model A: scripted replies, configurable latency, holdoff-ready forcing and mute
    rep_t        a_rep[$];
    exp_t        sb_a[$];
    int          a_lat, a_cnt;
    logic        a_force, a_mute, a_gap_chk;
    int unsigned a_exp_cnt;
    logic [15:0] a_exp_last;
    int          a_last_go;
    logic [31:0] prev_a;

    // model B: counts up through the 8-bit primes, then reports overflow
    exp_t        sb_b[$];
    int          b_cnt, b_last;
    int unsigned b_exp_cnt;
    logic [31:0] prev_b;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(input int n);
        for (int c = n + 1; c < 1000; c++) if (is_prime(c)) return c;
        return 1000;
    endfunction

    task automatic model_a();
        rep_t r;
        if (pgif_a.pg_go) begin
            pgif_a.pg_ready = a_force;
            a_cnt = a_lat;
        end else if (a_cnt != 0) begin
            a_cnt--;
            pgif_a.pg_ready = 1'b0;
            if (a_cnt == 0 && !a_mute && a_rep.size() != 0) begin
                r = a_rep.pop_front();
                pgif_a.pg_error = r.err;
                pgif_a.pg_res   = r.res;
                pgif_a.pg_ready = 1'b1;
                if (!r.err && ((a_exp_cnt == 0) ? (r.res >= 16'd2) : (r.res > a_exp_last))) begin
                    a_exp_cnt++;
                    a_exp_last = r.res;
                    sb_a.push_back('{a_exp_cnt, r.res});
                end
            end
        end
    endtask

    task automatic model_b();
        int p;
        if (pgif_b.pg_go) begin
            pgif_b.pg_ready = 1'b0;
            b_cnt = 3;
        end else if (b_cnt != 0) begin
            b_cnt--;
            pgif_b.pg_ready = 1'b0;
            if (b_cnt == 0) begin
                p = next_prime(b_last);
                pgif_b.pg_ready = 1'b1;
                if (p > 255) begin
                    pgif_b.pg_error = 1'b1;
                end else begin
                    pgif_b.pg_res = 8'(p);
                    b_last = p;
                    b_exp_cnt++;
                    sb_b.push_back('{b_exp_cnt, 16'(p)});
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (prime_count_a != prev_a && prime_count_a != 0) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_accept", prime_count_a, prev_a);
            end else begin
                e = sb_a.pop_front();
                check("a_sb_count", prime_count_a, e.cnt);
                check("a_sb_last", last_prime_a, e.last);
            end
        end
        prev_a = prime_count_a;
        if (pgif_a.pg_go) begin
            if (a_gap_chk && a_last_go >= 0) check("a_go_gap", cyc - a_last_go, 4);
            a_last_go = cyc;
        end
        if (prime_count_b != prev_b && prime_count_b != 0) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_accept", prime_count_b, prev_b);
            end else begin
                e = sb_b.pop_front();
                check("b_sb_count", prime_count_b, e.cnt);
                check("b_sb_last", last_prime_b, e.last);
            end
        end
        prev_b = prime_count_b;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model_a();
        model_b();
        monitor();
    endtask

    task automatic reset_models();
        pgif_a.pg_ready = 1'b0; pgif_a.pg_error = 1'b0; pgif_a.pg_res = '0;
        pgif_b.pg_ready = 1'b0; pgif_b.pg_error = 1'b0; pgif_b.pg_res = '0;
        a_rep.delete(); sb_a.delete(); sb_b.delete();
        a_lat = 3; a_cnt = 0; a_force = 1'b0; a_mute = 1'b0; a_gap_chk = 1'b0;
        a_exp_cnt = 0; a_exp_last = '0; a_last_go = -1; prev_a = '0;
        b_cnt = 0; b_last = 1; b_exp_cnt = 0; prev_b = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        reset_models();
        rst_n = 1'b1;
    endtask

    task automatic load_a(input logic [15:0] v0, v1, v2, v3, v4, input int n);
        logic [15:0] vals [5];
        vals = '{v0, v1, v2, v3, v4};
        for (int i = 0; i < n; i++) a_rep.push_back('{1'b0, vals[i]});
    endtask

    task automatic wait_end_a(input int budget);
        int n = 0;
        while (!(done_a || fail_a) && n < budget) begin tick(); n++; end
        if (!(done_a || fail_a)) check("a_run_end", done_a | fail_a, 1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        reset_models();
        tick();
        tick();
        check("rst_go", pgif_a.pg_go, 0);
        check("rst_done", done_a, 0);
        check("rst_fail", fail_a, 0);
        check("rst_code", fail_code_a, FC_NONE);
        check("rst_last", last_prime_a, 0);
        check("rst_count", prime_count_a, 0);
        check("rst_cycles", cycles_a, 0);
        check("rst_led", led_a, 0);
        rst_n = 1'b1;

        // MODE=1, 8-bit: runs through every prime up to 251, overflow ends the run as a pass
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!(done_b || fail_b) && n < 1000) begin tick(); n++; end
        check("t2_done", done_b, 1);
        check("t2_fail", fail_b, 0);
        check("t2_last", last_prime_b, 251);
        check("t2_count", prime_count_b, 54);
        check("t2_cycles", cycles_b, 220);
        check("t2_led", led_b, 5'b11111);
        check("t2_sb_left", sb_b.size(), 0);

        // LIMIT=5 with start held high for the whole run
        do_reset();
        load_a(2, 3, 5, 7, 11, 5);
        start_a = 1'b1;
        wait_end_a(200);
        check("t1_done", done_a, 1);
        check("t1_fail", fail_a, 0);
        check("t1_code", fail_code_a, FC_NONE);
        check("t1_count", prime_count_a, 5);
        check("t1_last", last_prime_a, 11);
        check("t1_cycles", cycles_a, 20);
        check("t1_led", led_a, 5'b10000);
        check("t1_sb_left", sb_a.size(), 0);
        repeat (3) tick();
        start_a = 1'b0;
        check("t1_cycles_frozen", cycles_a, 20);
        check("t1_go_idle", pgif_a.pg_go, 0);

        // repeated value breaks ordering; status LED then blinks with period 2*2**2
        do_reset();
        load_a(2, 3, 3, 0, 0, 3);
        pulse_start_a();
        wait_end_a(200);
        check("t3_fail", fail_a, 1);
        check("t3_done", done_a, 0);
        check("t3_code", fail_code_a, FC_ORDER);
        check("t3_last", last_prime_a, 3);
        check("t3_count", prime_count_a, 2);
        check("t3_sb_left", sb_a.size(), 0);
        for (int j = 0; j < 12; j++) begin
            check("t3_blink", led_a[4], ((j >> 2) & 1) == 0);
            check("t3_led_low", led_a[3:0], 0);
            tick();
        end

        // silent generator: timeout fires 11 cycles after the go pulse
        do_reset();
        a_mute = 1'b1;
        pulse_start_a();
        wait_end_a(200);
        check("t4_fail", fail_a, 1);
        check("t4_code", fail_code_a, FC_TIMEOUT);
        check("t4_latency", cyc - a_last_go, 11);
        check("t4_count", prime_count_a, 0);
        check("t4_cycles", cycles_a, 11);

        // stale ready during the holdoff cycle must be ignored every time
        do_reset();
        a_force = 1'b1;
        a_gap_chk = 1'b1;
        load_a(2, 3, 5, 7, 11, 5);
        pulse_start_a();
        wait_end_a(200);
        check("t5_done", done_a, 1);
        check("t5_fail", fail_a, 0);
        check("t5_count", prime_count_a, 5);
        check("t5_cycles", cycles_a, 20);
        check("t5_sb_left", sb_a.size(), 0);

        // asynchronous reset in the middle of the third request, then a clean rerun
        do_reset();
        load_a(2, 3, 5, 7, 11, 5);
        pulse_start_a();
        n = 0;
        while (prime_count_a != 2 && n < 200) begin tick(); n++; end
        check("t6_reach_two", prime_count_a, 2);
        n = 0;
        while (!pgif_a.pg_go && n < 20) begin tick(); n++; end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_go", pgif_a.pg_go, 0);
        check("t6_done", done_a, 0);
        check("t6_fail", fail_a, 0);
        check("t6_code", fail_code_a, FC_NONE);
        check("t6_last", last_prime_a, 0);
        check("t6_count", prime_count_a, 0);
        check("t6_cycles", cycles_a, 0);
        check("t6_led", led_a, 0);
        tick();
        reset_models();
        rst_n = 1'b1;
        load_a(2, 3, 5, 7, 11, 5);
        pulse_start_a();
        wait_end_a(200);
        check("t6_rerun_done", done_a, 1);
        check("t6_rerun_count", prime_count_a, 5);
        check("t6_rerun_last", last_prime_a, 11);
        check("t6_rerun_cycles", cycles_a, 20);
        check("t6_sb_left", sb_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
